// File: rtl/key_debounce_pulse.sv
// ---------------------------------------------------------------------------
// key_debounce_pulse
//
// Turns a raw, bouncing push-button/switch level into a clean debounced level
// in the CLK domain, plus one-cycle press and release pulses. The input passes
// through a 2-FF synchronizer. A 4-state FSM with a stability counter then
// accepts a level change only after the synchronized level has held for
// DEBOUNCE_CYCLES counted cycles.
//
// Parameters:
//   DEBOUNCE_CYCLES : stable synchronized samples needed to accept a change
//                     (2 .. 2**CNT_W)
//   CNT_W           : debounce counter width; must hold DEBOUNCE_CYCLES-1
//
// Ports:
//   CLK         in   system clock, rising edge
//   RST_n       in   asynchronous active-low reset, clears all state
//   KEY_IN      in   raw asynchronous key level (1 = pressed by default)
//   KEY_STATE   out  debounced level, registered
//   KEY_PRESS   out  one-cycle pulse on an accepted 0->1 change, registered
//   KEY_RELEASE out  one-cycle pulse on an accepted 1->0 change, registered
//
// Build option:
//   KEY_ACTIVE_LOW_EN : when defined, KEY_IN is active-low (idle 1). It is
//                       inverted ahead of the synchronizer, so the
//                       synchronizer reset value 0 means "released" in both
//                       builds. All outputs stay active-high.
// ---------------------------------------------------------------------------
module key_debounce_pulse #(
  parameter int DEBOUNCE_CYCLES = 20,
  parameter int CNT_W           = 20
) (
  input  logic CLK,
  input  logic RST_n,
  input  logic KEY_IN,
  output logic KEY_STATE,
  output logic KEY_PRESS,
  output logic KEY_RELEASE
);

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_PRESS_WAIT   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_RELEASE_WAIT = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] LP_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             w_key_act;
  logic             r_sync_p0;
  logic             r_sync_p1;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_key_state;
  logic             w_key_state_nxt;
  logic             r_key_press;
  logic             w_key_press_nxt;
  logic             r_key_release;
  logic             w_key_release_nxt;

`ifdef KEY_ACTIVE_LOW_EN
  assign w_key_act = ~KEY_IN;
`else
  assign w_key_act = KEY_IN;
`endif

  // Stage p0/p1: two-flop synchronizer, 0 = released after reset
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_sync_p0 <= 1'b0;
      r_sync_p1 <= 1'b0;
    end else begin
      r_sync_p0 <= w_key_act;
      r_sync_p1 <= r_sync_p0;
    end
  end

  // FSM state, counter and registered outputs
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_key_state   <= 1'b0;
      r_key_press   <= 1'b0;
      r_key_release <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_key_state   <= w_key_state_nxt;
      r_key_press   <= w_key_press_nxt;
      r_key_release <= w_key_release_nxt;
    end
  end

  // Next-state logic. The counter restarts on every bounce, and it is only
  // advanced while it is below LP_CNT_MAX, so it can never wrap.
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_key_state_nxt   = r_key_state;
    w_key_press_nxt   = 1'b0;
    w_key_release_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_key_state_nxt = 1'b0;
        if (r_sync_p1) begin
          w_state_nxt = ST_PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_PRESS_WAIT: begin
        if (!r_sync_p1) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_MAX) begin
          w_state_nxt     = ST_PRESSED;
          w_key_state_nxt = 1'b1;
          w_key_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      ST_PRESSED: begin
        w_key_state_nxt = 1'b1;
        if (!r_sync_p1) begin
          w_state_nxt = ST_RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      ST_RELEASE_WAIT: begin
        if (r_sync_p1) begin
          w_state_nxt = ST_PRESSED;
          w_cnt_nxt   = '0;
        end else if (r_cnt == LP_CNT_MAX) begin
          w_state_nxt       = ST_IDLE;
          w_key_state_nxt   = 1'b0;
          w_key_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt     = ST_IDLE;
        w_cnt_nxt       = '0;
        w_key_state_nxt = 1'b0;
      end
    endcase
  end

  assign KEY_STATE   = r_key_state;
  assign KEY_PRESS   = r_key_press;
  assign KEY_RELEASE = r_key_release;

endmodule
